// File: rtl/rr_mux_nbit.sv
// CH-channel, N-bit registered multiplexer with fixed-select or round-robin grant.
// Optional RR_MUX_BEAT_CNT_EN adds a 16-bit output-handshake counter (beat_cnt).
module rr_mux_nbit #(
    parameter int N  = 4,
    parameter int CH = 4,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
`ifdef RR_MUX_BEAT_CNT_EN
    ,
    output logic [15:0]     beat_cnt
`endif
);

    logic            load;
    logic            gnt_vld;
    logic [SW-1:0]   gnt_idx;
    logic [CH-1:0]   grant;
    logic [SW:0]     rr_sum;
    logic [N-1:0]    sel_data;

    logic [N-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SW-1:0]   last_q, last_d;

    assign load = ~out_valid_q | out_ready;

    // Round-robin scans in descending order so the last hit is the first channel after last_q.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        if (!mode) begin
            for (int i = 0; i < CH; i++) begin
                if (s == SW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            for (int k = CH; k >= 1; k--) begin
                rr_sum = {1'b0, last_q} + (SW+1)'(k);
                if (rr_sum >= (SW+1)'(CH)) begin
                    rr_sum = rr_sum - (SW+1)'(CH);
                end
                if (in_valid[rr_sum[SW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_sum[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt_vld && gnt_idx == SW'(i)) begin
                grant[i] = 1'b1;
                sel_data = in_data[i*N +: N];
            end
        end
    end

    assign in_ready = rst ? '0 : (grant & {CH{load}});

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (gnt_vld && load) begin
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            last_d      = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SW'(CH-1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef RR_MUX_BEAT_CNT_EN
    logic [15:0] beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else if (out_valid_q && out_ready) begin
            beat_q <= beat_q + 16'd1;
        end
    end

    assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_rr_mux_nbit.sv
// Scoreboard bench for rr_mux_nbit: driver + reference model push expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_rr_mux_nbit;
    localparam int N  = 4;
    localparam int CH = 4;
    localparam int SW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*N-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH-1:0]   in_ready;
    logic            mode = 1'b0;
    logic [SW-1:0]   s = '0;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready = 1'b0;
`ifdef RR_MUX_BEAT_CNT_EN
    logic [15:0]     beat_cnt;
`endif

    rr_mux_nbit #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s         (s),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MUX_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (register contents after the upcoming edge).
    bit          m_valid = 0;
    int          m_data  = 0;
    int          m_ch    = 0;
    int          m_last  = CH-1;
    int          m_beat  = 0;
    // Values the DUT must show during the current cycle.
    int          exp_valid_now, exp_data_now, exp_ch_now, exp_beat_now, exp_ready;
    bit          started = 0;
    int          sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        else n_pass++;
    endtask

    function automatic int model_grant(bit md, int sel, bit [CH-1:0] v, int last);
        if (!md) return (sel < CH && v[sel]) ? sel : -1;
        for (int k = 1; k <= CH; k++) begin
            int c = (last + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input bit md, input int sel, input logic [CH-1:0] v,
                        input logic [CH*N-1:0] d, input bit ordy);
        int  g;
        bit  ld;
        @(posedge clk);
        #1;
        rst       = r;
        mode      = md;
        s         = SW'(sel);
        in_valid  = v;
        in_data   = d;
        out_ready = r ? 1'b0 : ordy;
        exp_valid_now = int'(m_valid);
        exp_data_now  = m_data;
        exp_ch_now    = m_ch;
        exp_beat_now  = m_beat;
        if (r) begin
            exp_ready = 0;
            sb_q.delete();
            m_valid = 0; m_data = 0; m_ch = 0; m_last = CH-1; m_beat = 0;
        end else begin
            g  = model_grant(md, sel, v, m_last);
            ld = !m_valid || ordy;
            exp_ready = (g >= 0 && ld) ? (1 << g) : 0;
            if (m_valid && ordy) m_beat = (m_beat + 1) % 65536;
            if (g >= 0 && ld) begin
                m_data  = int'(d[g*N +: N]);
                m_ch    = g;
                m_valid = 1;
                m_last  = g;
                sb_q.push_back((m_ch << N) | m_data);
            end else if (ordy) begin
                m_valid = 0;
            end
        end
        started = 1;
    endtask

    // Monitor: current-cycle state checks plus scoreboard pop on each handshake.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("out_valid", 32'(out_valid), 32'(exp_valid_now));
                chk("out_data_hold", 32'(out_data), 32'(exp_data_now));
                chk("out_ch_hold", 32'(out_ch), 32'(exp_ch_now));
                chk("in_ready", 32'(in_ready), 32'(exp_ready));
`ifdef RR_MUX_BEAT_CNT_EN
                chk("beat_cnt", 32'(beat_cnt), 32'(exp_beat_now));
`endif
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_output", 32'(out_ch), 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_out_data", 32'(out_data), 32'(e & ((1 << N) - 1)));
                        chk("sb_out_ch", 32'(out_ch), 32'(e >> N));
                    end
                end
            end
        end
    end

    initial begin
        logic [CH*N-1:0] d;
        bit              md;
        bit              r;
        // Reset with every channel offering data.
        step(1, 0, 0, 4'b1111, 16'h1234, 1);
        step(1, 0, 0, 4'b1111, 16'h1234, 1);
        // Fixed select of channel 2 (data A).
        step(0, 0, 2, 4'b1111, 16'h3A56, 1);
        step(0, 0, 2, 4'b0000, 16'h0000, 1);
        // Round-robin fairness, two full rotations.
        step(1, 1, 0, 4'b1111, 16'h0000, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 4'b1111, (CH*N)'($urandom), 1);
        // Sparse round-robin from the reset pointer.
        step(1, 1, 0, 4'b1010, 16'h0000, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1010, (CH*N)'($urandom), 1);
        // Backpressure then release.
        step(0, 1, 0, 4'b1111, 16'h9876, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1111, (CH*N)'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1111, (CH*N)'($urandom), 1);
        // Handshakes, then mid-operation reset; next grant must be channel 0.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'b1111, (CH*N)'($urandom), 1);
        step(1, 1, 0, 4'b1111, 16'h0000, 1);
        step(0, 1, 0, 4'b1111, 16'hBCDE, 1);
        step(0, 1, 0, 4'b0000, 16'h0000, 1);
        // Randomised traffic with occasional resets and mode/select changes.
        for (int i = 0; i < 3000; i++) begin
            d  = (CH*N)'($urandom);
            md = 1'($urandom);
            r  = ($urandom_range(0, 99) == 0);
            step(r, md, int'($urandom_range(0, CH-1)), CH'($urandom), d,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, 16'h0000, 1);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
